// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_2r1w
//  Purpose  : Parametrised register file with one write port and two
//             independent combinational read ports (A/B operands). Includes
//             optional same-cycle write-to-read bypass, per-register valid
//             bits and a sequenced flash-clear engine that zeroes one
//             register per cycle.
//  Ports    : clk, reset      - clock, synchronous active-high reset
//             data_in         - write data
//             writenum, write - write index and enable
//             readnum_a/b     - read indices
//             data_out_a/b    - read data (combinational)
//             clear_req       - start a clear sequence (sampled in IDLE)
//             clear_busy      - high while the clear is sequencing
//             clear_done      - one-cycle pulse after the last register
//             reg_valid       - bit i set when register i holds written data
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int BYPASS     = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [ADDR_WIDTH-1:0]      writenum,
  input  logic                       write,
  input  logic [ADDR_WIDTH-1:0]      readnum_a,
  input  logic [ADDR_WIDTH-1:0]      readnum_b,
  output logic [DATA_WIDTH-1:0]      data_out_a,
  output logic [DATA_WIDTH-1:0]      data_out_b,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done,
  output logic [(1<<ADDR_WIDTH)-1:0] reg_valid
);

  localparam int N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_last_idx = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   regs_q [N];
  logic [DATA_WIDTH-1:0]   regs_d [N];
  logic [N-1:0]            valid_q, valid_d;

  logic                    wr_en;
  logic                    fwd_a;
  logic                    fwd_b;

  // Writes are dropped while the clear engine owns the array.
  assign wr_en = write && (state_q != S_CLEAR);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    valid_d = valid_q;

    if (wr_en) begin
      regs_d[writenum]  = data_in;
      valid_d[writenum] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end
      end
      S_CLEAR: begin
        regs_d[cnt_q]  = '0;
        valid_d[cnt_q] = 1'b0;
        cnt_d          = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == c_last_idx) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // clear_req here is deliberately ignored, not queued.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= '0;
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      for (int i = 0; i < N; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports with optional forwarding of the in-flight write
  // --------------------------------------------------------------------------
  if (BYPASS != 0) begin : g_bypass
    assign fwd_a = wr_en && (writenum == readnum_a);
    assign fwd_b = wr_en && (writenum == readnum_b);
  end else begin : g_no_bypass
    assign fwd_a = 1'b0;
    assign fwd_b = 1'b0;
  end

  assign data_out_a = fwd_a ? data_in : regs_q[readnum_a];
  assign data_out_b = fwd_b ? data_in : regs_q[readnum_b];

  // Decoded straight from the state register, so both are glitch-free.
  assign clear_busy = (state_q == S_CLEAR);
  assign clear_done = (state_q == S_DONE);
  assign reg_valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_2r1w
//  Purpose  : Directed self-checking bench for regfile_2r1w. Three instances:
//             default (bypass on), bypass off, and a 32-bit x 16 variant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [15:0] data_in;
  logic [2:0]  writenum, readnum_a, readnum_b;
  logic        write, clear_req;

  logic [15:0] a0, b0, a1, b1;
  logic        busy0, done0, busy1, done1;
  logic [7:0]  valid0, valid1;

  logic [31:0] w_data_in;
  logic [3:0]  w_writenum, w_readnum_a, w_readnum_b;
  logic        w_write, w_clear_req;
  logic [31:0] a2, b2;
  logic        busy2, done2;
  logic [15:0] valid2;

  int n_checks = 0;
  int n_errors = 0;

  regfile_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1)) u_dut_byp (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
    .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(a0), .data_out_b(b0), .clear_req(clear_req),
    .clear_busy(busy0), .clear_done(done0), .reg_valid(valid0)
  );

  regfile_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(0)) u_dut_nobyp (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum),
    .write(write), .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(a1), .data_out_b(b1), .clear_req(clear_req),
    .clear_busy(busy1), .clear_done(done1), .reg_valid(valid1)
  );

  regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYPASS(1)) u_dut_wide (
    .clk(clk), .reset(reset), .data_in(w_data_in), .writenum(w_writenum),
    .write(w_write), .readnum_a(w_readnum_a), .readnum_b(w_readnum_b),
    .data_out_a(a2), .data_out_b(b2), .clear_req(w_clear_req),
    .clear_busy(busy2), .clear_done(done2), .reg_valid(valid2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [15:0] val);
    write = 1'b1; writenum = idx; data_in = val;
    tick();
    write = 1'b0;
  endtask

  int busy_cnt;
  int done_cnt;

  initial begin
    reset = 1'b1; data_in = '0; writenum = '0; write = 1'b0;
    readnum_a = '0; readnum_b = '0; clear_req = 1'b0;
    w_data_in = '0; w_writenum = '0; w_write = 1'b0;
    w_readnum_a = '0; w_readnum_b = '0; w_clear_req = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_valid", 32'(valid0), 32'd0);
    check("rst_a", 32'(a0), 32'd0);
    check("rst_wide_valid", 32'(valid2), 32'd0);

    // ---------------- basic two-port read ----------------
    wr(3'd3, 16'h1234);
    wr(3'd7, 16'hBEEF);
    readnum_a = 3'd3; readnum_b = 3'd7;
    #1;
    check("rd_a_r3", 32'(a0), 32'h1234);
    check("rd_b_r7", 32'(b0), 32'hBEEF);
    check("valid_r3r7", 32'(valid0), 32'h88);
    check("nobyp_rd_b_r7", 32'(b1), 32'hBEEF);

    // ---------------- bypass vs no bypass ----------------
    readnum_a = 3'd2; readnum_b = 3'd2;
    write = 1'b1; writenum = 3'd2; data_in = 16'hA5A5;
    #1;
    check("byp_a", 32'(a0), 32'hA5A5);
    check("byp_b", 32'(b0), 32'hA5A5);
    check("nobyp_a_old", 32'(a1), 32'h0);
    check("nobyp_b_old", 32'(b1), 32'h0);
    tick();
    write = 1'b0;
    #1;
    check("nobyp_a_new", 32'(a1), 32'hA5A5);
    check("byp_a_stored", 32'(a0), 32'hA5A5);

    // ---------------- fill and clear ----------------
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(16'h0011 * i + 1));
    #1;
    check("fill_valid", 32'(valid0), 32'hFF);
    clear_req = 1'b1;
    tick();                                   // edge T0
    clear_req = 1'b0;
    readnum_b = 3'd7;
    for (int k = 0; k < 8; k++) begin         // cycle T0+1+k
      readnum_a = 3'(k);
      #1;
      check("clr_busy", 32'(busy0), 32'd1);
      check("clr_rk_old", 32'(a0), 32'(16'h0011 * k + 1));
      check("clr_r7_old", 32'(b0), 32'h0078);
      tick();
      #1;
      check("clr_rk_zero", 32'(a0), 32'h0);
      if (k < 7) begin
        readnum_a = 3'(k + 1);
        #1;
      end
    end
    // now in cycle T0+9
    check("clr_end_busy", 32'(busy0), 32'd0);
    check("clr_done", 32'(done0), 32'd1);
    check("clr_done_nobyp", 32'(done1), 32'd1);
    check("clr_valid", 32'(valid0), 32'h0);
    check("clr_r7_zero", 32'(b0), 32'h0);
    tick();
    check("clr_done_pulse", 32'(done0), 32'd0);

    // ---------------- write + clear_req during CLEAR ----------------
    wr(3'd5, 16'h5555);
    clear_req = 1'b1;
    tick();                                   // edge T0
    clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    readnum_a = 3'd5;
    for (int i = 0; i < 14; i++) begin
      if (i == 0) begin
        write = 1'b1; writenum = 3'd5; data_in = 16'hFFFF; clear_req = 1'b1;
        #1;
        check("clr_no_fwd", 32'(a0), 32'h5555);
      end
      #1;
      if (busy0) busy_cnt++;
      if (done0) done_cnt++;
      tick();
      write = 1'b0; clear_req = 1'b0;
    end
    check("clr2_busy_cnt", 32'(busy_cnt), 32'd8);
    check("clr2_done_cnt", 32'(done_cnt), 32'd1);
    #1;
    check("clr2_r5", 32'(a0), 32'h0);
    check("clr2_valid", 32'(valid0), 32'h0);

    // ---------------- reset in the middle of a clear ----------------
    wr(3'd1, 16'h7777);
    wr(3'd6, 16'h6666);
    clear_req = 1'b1;
    tick();                                   // edge T0
    clear_req = 1'b0;
    tick(); tick(); tick();                   // now in cycle T0+4
    #1;
    check("mid_busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    readnum_a = 3'd6; readnum_b = 3'd1;
    #1;
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_r6", 32'(a0), 32'h0);
    check("mid_rst_valid", 32'(valid0), 32'h0);
    tick();
    check("mid_rst_done2", 32'(done0), 32'd0);
    wr(3'd1, 16'h0042);
    #1;
    check("post_rst_r1", 32'(b0), 32'h0042);
    check("post_rst_valid", 32'(valid0), 32'h02);

    // ---------------- wide instance ----------------
    w_write = 1'b1; w_writenum = 4'd15; w_data_in = 32'hDEADBEEF;
    tick();
    w_write = 1'b0;
    w_readnum_a = 4'd15; w_readnum_b = 4'd15;
    #1;
    check("wide_a", a2, 32'hDEADBEEF);
    check("wide_b", b2, 32'hDEADBEEF);
    check("wide_valid", 32'(valid2), 32'h8000);
    w_clear_req = 1'b1;
    tick();
    w_clear_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (busy2) busy_cnt++;
      if (done2) done_cnt++;
      tick();
    end
    check("wide_busy_cnt", 32'(busy_cnt), 32'd16);
    check("wide_done_cnt", 32'(done_cnt), 32'd1);
    #1;
    check("wide_r15_zero", a2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
